// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: binary-angle constants (2^32 = 2*pi), the 1/K
// magnitude correction factor, the polar engine state type and the
// arctangent table used by the micro-rotation steps.
//
// Build option: define POLAR_MAG_EN to include the magnitude scaling state.
package cordic_pkg;

  localparam logic [31:0] PI    = 32'h8000_0000;
  localparam logic [31:0] PI_2  = 32'h4000_0000;
  localparam logic [31:0] PI_4  = 32'h2000_0000;

  // 1/K for the CORDIC gain, Q0.16 (0.607253 * 65536).
  localparam logic [15:0] INV_K = 16'd39797;

  localparam int unsigned AtanDepth = 24;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StIter,
`ifdef POLAR_MAG_EN
    StScale,
`endif
    StDone
  } state_e;

  // ATAN[i] = atan(2^-i) as a 32-bit binary angle.
  localparam logic [31:0] ATAN [AtanDepth] = '{
    32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
    32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
    32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
    32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
    32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
    32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051
  };

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent lookup for CORDIC micro-rotations.
//
// Ports:
//   idx_i  - micro-rotation index (0..23); out-of-range indices return 0
//   atan_o - atan(2^-idx_i) as a 32-bit binary angle
module cordic_atan_rom
  import cordic_pkg::*;
(
  input  logic [4:0]  idx_i,
  output logic [31:0] atan_o
);

  always_comb begin
    atan_o = '0;
    if (idx_i < 5'(AtanDepth)) begin
      atan_o = ATAN[idx_i];
    end
  end

endmodule

// File: rtl/polar.sv
// Cartesian-to-polar converter built around a single iterative CORDIC engine
// in vectoring mode. One sample is in flight at a time.
//
// Build option: POLAR_MAG_EN - when defined, a SCALE state applies 1/K to the
// rotated x and reports magnitude in m_data[16:0]; when undefined, m_data[31:0]
// is zero and ITER goes straight to DONE.
//
// Ports:
//   clk, reset_n      - clock and asynchronous active-low reset
//   s_valid/s_ready   - input handshake; s_data = {imag, real}, Q1.15 each
//   s_last            - frame marker carried through to m_last
//   m_valid/m_ready   - output handshake; m_data = {phase, 15'b0, magnitude}
//   m_last            - s_last of the sample that produced m_data
module polar
  import cordic_pkg::*;
#(
  parameter int unsigned ITERATIONS = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  input  logic        s_last,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [63:0] m_data,
  output logic        m_last
);

  localparam logic [4:0] LastStep = 5'(ITERATIONS - 1);

  state_e             state_q, state_d;
  logic signed [18:0] x_q, x_d;
  logic signed [18:0] y_q, y_d;
  logic [31:0]        z_q, z_d;
  logic [4:0]         step_q, step_d;
  logic               last_q, last_d;
  logic               zero_q, zero_d;
  logic               s_ready_q, s_ready_d;
  logic [31:0]        atan;

`ifdef POLAR_MAG_EN
  logic [16:0]        mag_q, mag_d;
  logic signed [36:0] prod;
  logic signed [36:0] prod_sh;

  // x is non-negative after vectoring; round-to-nearest then saturate.
  assign prod    = 37'(x_q) * 37'(signed'({1'b0, INV_K}));
  assign prod_sh = (prod + 37'sd32768) >>> 16;
`endif

  cordic_atan_rom u_atan_rom (
    .idx_i  (step_q),
    .atan_o (atan)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      step_q    <= '0;
      last_q    <= 1'b0;
      zero_q    <= 1'b0;
      s_ready_q <= 1'b0;
`ifdef POLAR_MAG_EN
      mag_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      step_q    <= step_d;
      last_q    <= last_d;
      zero_q    <= zero_d;
      s_ready_q <= s_ready_d;
`ifdef POLAR_MAG_EN
      mag_q     <= mag_d;
`endif
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    step_d  = step_q;
    last_d  = last_q;
    zero_d  = zero_q;
`ifdef POLAR_MAG_EN
    mag_d   = mag_q;
`endif

    case (state_q)
      StIdle: begin
        if (s_valid && s_ready_q) begin
          x_d     = 19'(signed'(s_data[15:0]));
          y_d     = 19'(signed'(s_data[31:16]));
          last_d  = s_last;
          state_d = StPre;
        end
      end

      StPre: begin
        step_d = '0;
        // atan2(0,0) would otherwise accumulate the whole table.
        zero_d = (x_q == '0) && (y_q == '0);
        // Rotate left half-plane by pi so vectoring converges; 19 bits hold +32768.
        if (x_q[18]) begin
          x_d = -x_q;
          y_d = -y_q;
          z_d = PI;
        end else begin
          z_d = '0;
        end
        state_d = StIter;
      end

      StIter: begin
        if (!y_q[18]) begin
          x_d = x_q + (y_q >>> step_q);
          y_d = y_q - (x_q >>> step_q);
          z_d = z_q + atan;
        end else begin
          x_d = x_q - (y_q >>> step_q);
          y_d = y_q + (x_q >>> step_q);
          z_d = z_q - atan;
        end
        if (zero_q) begin
          z_d = '0;
        end
        step_d = step_q + 5'd1;
        if (step_q == LastStep) begin
`ifdef POLAR_MAG_EN
          state_d = StScale;
`else
          state_d = StDone;
`endif
        end
      end

`ifdef POLAR_MAG_EN
      StScale: begin
        if (prod_sh[36]) begin
          mag_d = '0;
        end else if (prod_sh > 37'sd131071) begin
          mag_d = '1;
        end else begin
          mag_d = prod_sh[16:0];
        end
        state_d = StDone;
      end
`endif

      StDone: begin
        if (m_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // Registered so s_ready stays low while reset is held and rises on the first edge after.
  assign s_ready_d = (state_d == StIdle);

  // Outputs
  always_comb begin
    s_ready = s_ready_q;
    m_valid = (state_q == StDone);
    m_last  = m_valid & last_q;
    m_data  = '0;
    if (m_valid) begin
      m_data[63:32] = z_q;
`ifdef POLAR_MAG_EN
      m_data[16:0]  = mag_q;
`endif
    end
  end

endmodule
